// File: rtl/nibble_serial_sub_ctrl.sv
// nibble_serial_sub_ctrl
// Runs WIDTH-bit add/subtract operations through one shared 4-bit ripple-carry
// slice, one nibble per clock, LSB nibble first. Operands are captured on
// accept, the inter-nibble carry is registered, and the finished result plus
// flags are presented through a valid/ready handshake.
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_sub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands captured at accept; later input changes cannot reach the datapath.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;

    // Sequencing state.
    logic [IDX_W-1:0] idx;
    logic             carry_reg;

    // Result and flag registers driven straight onto the output ports.
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             zero_reg;
    logic             overflow_reg;

    // Combinational slice signals.
    logic             accept;
    logic             last_nibble;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       b_eff;
    logic [3:0]       sum_nib;
    logic             c_msb;
    logic             c_out;
    logic [WIDTH-1:0] result_next;

    // State register; reset aborts any operation in flight.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low while reset is asserted, not just after the edge.
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE never accepts in the same cycle.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept      = in_ready && in_valid;
    assign last_nibble = (idx == IDX_W'(N - 1));

    // Select the operand nibbles addressed by idx.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    // Subtraction inverts the subtrahend; the +1 enters through the carry
    // register, which is loaded with sub on accept.
    assign b_eff = b_nib ^ {4{sub_reg}};

    // Shared 4-bit ripple-carry slice, one full adder per bit.
    always_comb begin
        logic [4:0] chain;
        chain    = '0;
        sum_nib  = '0;
        chain[0] = carry_reg;
        for (int j = 0; j < 4; j++) begin
            sum_nib[j]   = a_nib[j] ^ b_eff[j] ^ chain[j];
            chain[j+1]   = (a_nib[j] & b_eff[j]) | (chain[j] & (a_nib[j] ^ b_eff[j]));
        end
        // chain[3] is the carry into the top bit of the slice; on the last
        // nibble that is the carry into bit WIDTH-1, needed for overflow.
        c_msb = chain[3];
        c_out = chain[4];
    end

    // Merge the fresh nibble into the partial result.
    always_comb begin
        result_next = result_reg;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                result_next[4*i +: 4] = sum_nib;
            end
        end
    end

    // Operand capture, nibble sequencing and result/flag accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            idx           <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            a_reg         <= a;
            b_reg         <= b;
            sub_reg       <= sub;
            idx           <= '0;
            carry_reg     <= sub;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (state == RUN) begin
            result_reg <= result_next;
            carry_reg  <= c_out;
            if (last_nibble) begin
                // idx parks on the last nibble; only accept or reset rewinds it.
                carry_out_reg <= c_out;
                overflow_reg  <= c_msb ^ c_out;
                zero_reg      <= (result_next == '0);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;

endmodule
